dram_refresh_sched: RTL and testbench

Schedules CAS-before-RAS refresh for the 8MB FastRAM DRAM array of the Zorro II card. It replaces the free-running inline refresh toggle that sits alongside the access sequencer. The block runs an interval timer and accumulates a bounded refresh debt. It issues refreshes opportunistically while the 68000 bus is idle, and escalates to a blocking request when the debt saturates. Its strobes feed the RAS1n–RAS4n/UCASn/LCASn/MEMWn decode and gate DTACK generation in the memory controller.

---
 rtl/gottagofast_pkg.sv | 17 +
 rtl/refresh_tick_gen.sv | 26 ++
 rtl/dram_refresh_sched.sv | 108 ++++++++++
 tb/tb_dram_refresh_sched.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/gottagofast_pkg.sv
// Shared types and default timing for the Zorro II FastRAM refresh scheduler.
package gottagofast_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CAS    = 2'd1,
      CASRAS = 2'd2,
      PRE    = 2'd3
   } ref_state_e;

   localparam int DEF_REFRESH_INTERVAL = 109;
   localparam int DEF_MAX_DEBT         = 8;
   localparam int DEF_RAS_CYCLES       = 2;
   localparam int DEF_PRE_CYCLES       = 1;
   localparam int DEBT_W               = 4;

endpackage

// File: rtl/refresh_tick_gen.sv
// Interval down-counter: emits a one-cycle tick every REFRESH_INTERVAL CLK cycles.
module refresh_tick_gen #(
   parameter int REFRESH_INTERVAL = 109
) (
   input  logic CLK,
   input  logic RESETn,
   output logic tick
);

   localparam int CNT_W = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(REFRESH_INTERVAL - 1);

   logic [CNT_W-1:0] count;

   assign tick = (count == '0);

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn)
         count <= RELOAD;
      else if (tick)
         count <= RELOAD;
      else
         count <= count - 1'b1;
   end

endmodule

// File: rtl/dram_refresh_sched.sv
// CBR refresh scheduler with bounded debt; opportunistic while the bus is idle, blocking when saturated.
// Optional back-to-back draining from PRE when REFRESH_BURST_EN is defined.
module dram_refresh_sched
   import gottagofast_pkg::*;
#(
   parameter int REFRESH_INTERVAL = DEF_REFRESH_INTERVAL,
   parameter int MAX_DEBT         = DEF_MAX_DEBT,
   parameter int RAS_CYCLES       = DEF_RAS_CYCLES,
   parameter int PRE_CYCLES       = DEF_PRE_CYCLES
) (
   input  logic              CLK,
   input  logic              RESETn,
   input  logic              ASn,
   input  logic              ram_busy,
   output logic              refresh_cas,
   output logic              refresh_ras,
   output logic              ref_active,
   output logic              ref_urgent,
   output logic              ref_lost,
   output logic [DEBT_W-1:0] debt
);

   localparam int CNT_W = 8;

   ref_state_e       state, state_nxt;
   logic [CNT_W-1:0] phase_cnt;
   logic             tick;
   logic             can_start;
   logic             start;

   refresh_tick_gen #(
      .REFRESH_INTERVAL(REFRESH_INTERVAL)
   ) u_tick (
      .CLK   (CLK),
      .RESETn(RESETn),
      .tick  (tick)
   );

   assign ref_urgent = (debt == DEBT_W'(MAX_DEBT));
   // An urgent refresh ignores the bus but still never cuts into a controller access.
   assign can_start  = (debt != '0) && !ram_busy && (ASn || ref_urgent);

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      case (state)
         IDLE: begin
            if (can_start) begin
               state_nxt = CAS;
               start     = 1'b1;
            end
         end
         CAS:    state_nxt = CASRAS;
         CASRAS: begin
            if (phase_cnt == CNT_W'(RAS_CYCLES - 1))
               state_nxt = PRE;
         end
         PRE: begin
            if (phase_cnt == CNT_W'(PRE_CYCLES - 1)) begin
`ifdef REFRESH_BURST_EN
               if (can_start) begin
                  state_nxt = CAS;
                  start     = 1'b1;
               end else begin
                  state_nxt = IDLE;
               end
`else
               state_nxt = IDLE;
`endif
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state     <= IDLE;
         phase_cnt <= '0;
      end else begin
         state     <= state_nxt;
         phase_cnt <= (state_nxt != state) ? '0 : phase_cnt + 1'b1;
      end
   end

   // Strobes decode straight from the state register so reset drops them at once.
   always_comb begin
      refresh_cas = (state == CAS) || (state == CASRAS);
      refresh_ras = (state == CASRAS);
      ref_active  = (state != IDLE);
   end

   // A tick absorbed by a simultaneous start leaves debt unchanged and is not lost.
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         debt     <= '0;
         ref_lost <= 1'b0;
      end else if (tick && !start) begin
         if (ref_urgent)
            ref_lost <= 1'b1;
         else
            debt <= debt + 1'b1;
      end else if (start && !tick) begin
         debt <= debt - 1'b1;
      end
   end

endmodule

// File: tb/tb_dram_refresh_sched.sv
// Randomized scoreboard bench for dram_refresh_sched against a cycle-count reference model.
module tb_dram_refresh_sched;

   localparam int INTERVAL = 109;
   localparam int MAXD     = 8;
   localparam int RASC     = 2;
   localparam int PREC     = 1;
   localparam int LEN      = 1 + RASC + PREC;
`ifdef REFRESH_BURST_EN
   localparam bit BURST = 1'b1;
`else
   localparam bit BURST = 1'b0;
`endif

   logic       CLK = 1'b0;
   logic       RESETn = 1'b0;
   logic       ASn = 1'b1;
   logic       ram_busy = 1'b0;
   logic       refresh_cas, refresh_ras, ref_active, ref_urgent, ref_lost;
   logic [3:0] debt;

   typedef struct packed {
      logic       cas;
      logic       ras;
      logic       act;
      logic       urg;
      logic       lost;
      logic [3:0] debt;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   bit   done = 1'b0;

   // Reference model: edge count since reset, debt, lost flag, and position inside a refresh (0 = none)
   int m_e, m_debt, m_t;
   bit m_lost;

   dram_refresh_sched #(
      .REFRESH_INTERVAL(INTERVAL),
      .MAX_DEBT        (MAXD),
      .RAS_CYCLES      (RASC),
      .PRE_CYCLES      (PREC)
   ) dut (
      .CLK        (CLK),
      .RESETn     (RESETn),
      .ASn        (ASn),
      .ram_busy   (ram_busy),
      .refresh_cas(refresh_cas),
      .refresh_ras(refresh_ras),
      .ref_active (ref_active),
      .ref_urgent (ref_urgent),
      .ref_lost   (ref_lost),
      .debt       (debt)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_e = 0; m_debt = 0; m_t = 0; m_lost = 1'b0;
   endfunction

   function automatic void model_step(input bit asn_v, input bit busy_v);
      bit tick, can, start;
      m_e++;
      tick  = (m_e % INTERVAL) == 0;
      can   = (m_debt > 0) && !busy_v && (asn_v || m_debt == MAXD);
      start = (m_t == 0 || (BURST && m_t == LEN)) ? can : 1'b0;
      if (start)                        m_t = 1;
      else if (m_t == 0 || m_t == LEN) m_t = 0;
      else                              m_t = m_t + 1;
      if (tick && !start) begin
         if (m_debt == MAXD) m_lost = 1'b1;
         else                m_debt++;
      end else if (start && !tick) begin
         m_debt--;
      end
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      e.cas  = (m_t >= 1) && (m_t <= 1 + RASC);
      e.ras  = (m_t >= 2) && (m_t <= 1 + RASC);
      e.act  = (m_t != 0);
      e.urg  = (m_debt == MAXD);
      e.lost = m_lost;
      e.debt = 4'(m_debt);
      return e;
   endfunction

   // Drive inputs, let one edge pass, advance model and queue its expectation.
   task automatic step(input bit asn_v, input bit busy_v);
      ASn = asn_v;
      ram_busy = busy_v;
      @(posedge CLK);
      model_step(asn_v, busy_v);
      q.push_back(model_out());
      #1;
   endtask

   // mode: 0 low, 1 high, 2 random
   task automatic run(input int n, input int asn_mode, input int busy_mode);
      bit a, b;
      for (int i = 0; i < n; i++) begin
         a = (asn_mode == 2) ? ($urandom_range(0, 3) != 0) : asn_mode[0];
         b = (busy_mode == 2) ? ($urandom_range(0, 2) == 0) : busy_mode[0];
         step(a, b);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, " refresh_cas"}, int'(refresh_cas), 0);
      chk({tag, " refresh_ras"}, int'(refresh_ras), 0);
      chk({tag, " ref_active"},  int'(ref_active), 0);
      chk({tag, " ref_urgent"},  int'(ref_urgent), 0);
      chk({tag, " ref_lost"},    int'(ref_lost), 0);
      chk({tag, " debt"},        int'(debt), 0);
   endtask

   task automatic apply_reset();
      RESETn = 1'b0;
      #1;
      q.delete();
      model_reset();
      check_reset_vals("async_reset");
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      RESETn = 1'b1;
   endtask

   // Monitor: compares every registered DUT output against the queued expectation.
   initial begin
      exp_t e;
      while (!done) begin
         @(negedge CLK);
         if (RESETn && q.size() > 0) begin
            e = q.pop_front();
            chk("refresh_cas", int'(refresh_cas), int'(e.cas));
            chk("refresh_ras", int'(refresh_ras), int'(e.ras));
            chk("ref_active",  int'(ref_active),  int'(e.act));
            chk("ref_urgent",  int'(ref_urgent),  int'(e.urg));
            chk("ref_lost",    int'(ref_lost),    int'(e.lost));
            chk("debt",        int'(debt),        int'(e.debt));
         end
      end
   end

   initial begin
      int  first_cas;
      bit  found;
      model_reset();
      repeat (3) @(posedge CLK);
      #1;
      check_reset_vals("reset");
      @(negedge CLK);
      RESETn = 1'b1;

      // Idle bus: first refresh strobe on edge 110
      first_cas = 0;
      for (int i = 1; i <= 200 && first_cas == 0; i++) begin
         step(1'b1, 1'b0);
         if (refresh_cas) first_cas = i;
      end
      chk("first_cas_cycle", first_cas, INTERVAL + 1);
      run(300, 1, 0);

      // Busy bus, no accesses: saturate then oscillate 7/8
      run(1000, 0, 0);
      // Controller holding RAM: debt saturates, ticks lost, no strobes
      run(1200, 0, 1);
      run(60, 0, 0);

      // Build debt of 5 then release the bus to drain it
      apply_reset();
      run(5 * INTERVAL + 5, 0, 0);
      chk("debt_before_drain", int'(debt), 5);
      run(60, 1, 0);

      // Tick coincident with start at debt 1
      apply_reset();
      run(2 * INTERVAL - 1, 0, 0);
      chk("debt_pre_coincide", int'(debt), 1);
      step(1'b1, 1'b0);
      chk("debt_coincide", int'(debt), 1);
      chk("active_coincide", int'(ref_active), 1);
      run(50, 1, 0);

      // Random traffic
      run(3000, 2, 2);

      // Reset pulsed during CASRAS
      found = 1'b0;
      for (int i = 0; i < 300 && !found; i++) begin
         step(1'b1, 1'b0);
         if (m_t == 2) found = 1'b1;
      end
      chk("reached_casras", int'(found), 1);
      chk("casras_ras_before_reset", int'(refresh_ras), 1);
      apply_reset();
      first_cas = 0;
      for (int i = 1; i <= 200 && first_cas == 0; i++) begin
         step(1'b1, 1'b0);
         if (refresh_cas) first_cas = i;
      end
      chk("cas_after_reset", first_cas, INTERVAL + 1);
      run(400, 2, 2);

      repeat (2) @(posedge CLK);
      done = 1'b1;
      @(negedge CLK);
      chk("queue_drained", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
